neuron_mac_sequencer: RTL and testbench

- Downstream consumer of the 10-entry data register bank: a single neuron evaluator.
- On start, it walks a 4-bit index over the bank's ten 32-bit outputs and a matching weight vector, one multiply-accumulate per clock, and adds a bias.
- It applies optional ReLU, saturates to 32 bits and presents the result on a valid/ready handshake to the next layer's loader.
- All values are signed fixed point, Q16.16 by default.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_mac_unit.sv | 30 +++
 rtl/neuron_mac_sequencer.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron evaluator.
//   - Default widths (data/weight/bias/result word, input count, fraction
//     bits, accumulator width).
//   - Sequencer state encoding.
//   - Q16.16 constants and the signed 32-bit saturation limits.
package nn_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int NUM_IN_DEF    = 10;
    localparam int FRAC_BITS_DEF = 16;
    localparam int ACC_W_DEF     = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } nn_state_t;

    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/nn_mac_unit.sv
// Combinational multiply-accumulate step for one neuron input.
//   data, weight : signed fixed-point operands (FRAC_BITS fraction bits)
//   acc_in       : current accumulator
//   acc_out      : acc_in + trunc_ACC_W((data * weight) >>> FRAC_BITS)
// The product is formed at full 2*DATA_W width, so even the most negative
// operand squared is representable before the rescaling shift.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic        [DATA_W-1:0] data,
    input  logic        [DATA_W-1:0] weight,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic signed [ACC_W-1:0]  acc_out
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [2*DATA_W-1:0] scaled_s;

    // Full-width signed product, rescale to the accumulator's binary point, accumulate.
    always_comb begin
        prod_s   = $signed(data) * $signed(weight);
        scaled_s = prod_s >>> FRAC_BITS;
        acc_out  = acc_in + $signed(scaled_s[ACC_W-1:0]);
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron evaluator fed by the 10-entry data register bank.
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : begin one evaluation (accepted only in IDLE)
//   data_flat    : NUM_IN packed data words, entry 0 in the LSBs
//   weight_flat  : NUM_IN packed weights, same packing
//   bias         : captured when start is accepted
//   busy         : high while accumulating (MAC) and activating (ACT)
//   out_valid    : result available; held until out_ready is seen
//   out_ready    : downstream accepts the result
//   result       : saturated (and optionally ReLU-clamped) neuron output
// One multiply-accumulate per clock over NUM_IN inputs; out_valid rises
// NUM_IN+1 edges after the accepting edge.
module neuron_mac_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_IN    = NUM_IN_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_IN*DATA_W-1:0] data_flat,
    input  logic [NUM_IN*DATA_W-1:0] weight_flat,
    input  logic [DATA_W-1:0]        bias,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        result
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);

    // Saturation limits of a DATA_W signed word, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    nn_state_t               state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic signed [ACC_W-1:0] acc_r, acc_s;
    logic [DATA_W-1:0]       result_r, result_s;
    logic                    out_valid_r, out_valid_s;
    logic                    busy_r, busy_s;

    logic [DATA_W-1:0]       data_sel_s;
    logic [DATA_W-1:0]       weight_sel_s;
    logic signed [ACC_W-1:0] mac_acc_s;
    logic [DATA_W-1:0]       sat_s;
    logic [DATA_W-1:0]       act_s;

    // Select the current input/weight pair; idx never leaves 0..NUM_IN-1.
    always_comb begin
        data_sel_s   = data_flat[idx_r*DATA_W +: DATA_W];
        weight_sel_s = weight_flat[idx_r*DATA_W +: DATA_W];
    end

    nn_mac_unit #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .data    (data_sel_s),
        .weight  (weight_sel_s),
        .acc_in  (acc_r),
        .acc_out (mac_acc_s)
    );

    // Clamp the accumulator to the signed word range, then apply optional ReLU.
    always_comb begin
        if (acc_r > ACC_MAX) begin
            sat_s = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_r < ACC_MIN) begin
            sat_s = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_s = acc_r[DATA_W-1:0];
        end

        if (RELU_EN && sat_s[DATA_W-1]) begin
            act_s = {DATA_W{1'b0}};
        end else begin
            act_s = sat_s;
        end
    end

    // Next-state and next-output logic of the evaluation sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        acc_s       = acc_r;
        result_s    = result_r;
        out_valid_s = out_valid_r;
        busy_s      = busy_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = MAC;
                    idx_s   = {IDX_W{1'b0}};
                    acc_s   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            MAC: begin
                acc_s = mac_acc_s;
                if (idx_r == IDX_LAST) begin
                    state_s = ACT;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end

            ACT: begin
                result_s    = act_s;
                out_valid_s = 1'b1;
                busy_s      = 1'b0;
                state_s     = HOLD;
            end

            HOLD: begin
                // start is deliberately not looked at here, even on the handshake edge.
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s     = HOLD;
                end
            end

            default: begin
                state_s     = IDLE;
                idx_s       = {IDX_W{1'b0}};
                acc_s       = {ACC_W{1'b0}};
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any evaluation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            result_r    <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            acc_r       <= acc_s;
            result_r    <= result_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
module tb_neuron_mac_sequencer;

    localparam int DW = 32;
    localparam int NI = 10;

    logic            clk;
    logic            rst;
    logic            start;
    logic [NI*DW-1:0] data_flat;
    logic [NI*DW-1:0] weight_flat;
    logic [DW-1:0]   bias;
    logic            out_ready;

    logic            busy_a, out_valid_a;
    logic [DW-1:0]   result_a;
    logic            busy_b, out_valid_b;
    logic [DW-1:0]   result_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ReLU enabled
    neuron_mac_sequencer #(.RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .data_flat(data_flat), .weight_flat(weight_flat), .bias(bias),
        .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .result(result_a)
    );

    // ReLU disabled
    neuron_mac_sequencer #(.RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .data_flat(data_flat), .weight_flat(weight_flat), .bias(bias),
        .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .result(result_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_vec(input logic [DW-1:0] d, input logic [DW-1:0] w);
        for (int i = 0; i < NI; i++) begin
            data_flat[i*DW +: DW]   = d;
            weight_flat[i*DW +: DW] = w;
        end
    endtask

    // Pulse start for the next edge and wait until out_valid; lat counts
    // edges after the accepting edge, bc counts post-edge samples with busy=1.
    task automatic run_eval(output int lat, output int bc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bc  = busy_a ? 1 : 0;
        while (!out_valid_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_a) bc++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; bias = 32'h0;
        set_vec(32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else pass_cnt++;
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid_a); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h0) $display("FAIL reset_result got=%h exp=0", result_a); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sum();
        int lat, bc;
        set_vec(32'h0001_0000, 32'h0001_0000);
        bias = 32'h0;
        run_eval(lat, bc);
        total_cnt++; if (lat !== 11) $display("FAIL basic_latency got=%0d exp=11", lat); else pass_cnt++;
        total_cnt++; if (bc !== 11) $display("FAIL basic_busy_cycles got=%0d exp=11", bc); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL basic_busy_hold got=%b exp=0", busy_a); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h000A_0000) $display("FAIL basic_result_relu got=%h exp=000a0000", result_a); else pass_cnt++;
        total_cnt++; if (result_b !== 32'h000A_0000) $display("FAIL basic_result_lin got=%h exp=000a0000", result_b); else pass_cnt++;
        accept();
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", out_valid_a); else pass_cnt++;
    endtask

    task automatic test_bias_signed();
        int lat, bc;
        set_vec(32'h0, 32'h0001_0000);
        bias = 32'h0001_8000;
        run_eval(lat, bc);
        total_cnt++; if (result_a !== 32'h0001_8000) $display("FAIL bias_only_relu got=%h exp=00018000", result_a); else pass_cnt++;
        total_cnt++; if (result_b !== 32'h0001_8000) $display("FAIL bias_only_lin got=%h exp=00018000", result_b); else pass_cnt++;
        accept();
        set_vec(32'h0, 32'h0);
        data_flat[31:0]   = 32'hFFFD_8000;
        weight_flat[31:0] = 32'h0001_0000;
        bias = 32'h0;
        run_eval(lat, bc);
        total_cnt++; if (result_a !== 32'h0000_0000) $display("FAIL neg_relu got=%h exp=00000000", result_a); else pass_cnt++;
        total_cnt++; if (result_b !== 32'hFFFD_8000) $display("FAIL neg_lin got=%h exp=fffd8000", result_b); else pass_cnt++;
        accept();
    endtask

    task automatic test_saturation();
        int lat, bc;
        set_vec(32'h7FFF_0000, 32'h7FFF_0000);
        bias = 32'h0;
        run_eval(lat, bc);
        total_cnt++; if (result_a !== 32'h7FFF_FFFF) $display("FAIL sat_max_relu got=%h exp=7fffffff", result_a); else pass_cnt++;
        total_cnt++; if (result_b !== 32'h7FFF_FFFF) $display("FAIL sat_max_lin got=%h exp=7fffffff", result_b); else pass_cnt++;
        accept();
        set_vec(32'h7FFF_0000, 32'h8001_0000);
        run_eval(lat, bc);
        total_cnt++; if (result_b !== 32'h8000_0000) $display("FAIL sat_min_lin got=%h exp=80000000", result_b); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h0000_0000) $display("FAIL sat_min_relu got=%h exp=00000000", result_a); else pass_cnt++;
        accept();
    endtask

    task automatic test_backpressure();
        int lat, bc;
        set_vec(32'h0001_0000, 32'h0001_0000);
        bias = 32'h0;
        out_ready = 1'b0;
        run_eval(lat, bc);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            total_cnt++; if (out_valid_a !== 1'b1) $display("FAIL bp_valid_held c=%0d got=%b exp=1", c, out_valid_a); else pass_cnt++;
            total_cnt++; if (result_a !== 32'h000A_0000) $display("FAIL bp_result_held c=%0d got=%h exp=000a0000", c, result_a); else pass_cnt++;
            total_cnt++; if (busy_a !== 1'b0) $display("FAIL bp_start_ignored c=%0d busy=%b exp=0", c, busy_a); else pass_cnt++;
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL bp_handshake_valid got=%b exp=0", out_valid_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL bp_handshake_start_ignored busy=%b exp=0", busy_a); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL bp_idle_after busy=%b exp=0", busy_a); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h000A_0000) $display("FAIL bp_result_kept got=%h exp=000a0000", result_a); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        int lat, bc;
        set_vec(32'h0001_0000, 32'h0001_0000);
        bias = 32'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy_a); else pass_cnt++;
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid_a); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h0) $display("FAIL midrst_result got=%h exp=0", result_a); else pass_cnt++;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL midrst_no_partial got=%b exp=0", out_valid_a); else pass_cnt++;
        run_eval(lat, bc);
        total_cnt++; if (lat !== 11) $display("FAIL midrst_latency got=%0d exp=11", lat); else pass_cnt++;
        total_cnt++; if (result_a !== 32'h000A_0000) $display("FAIL midrst_result_after got=%h exp=000a0000", result_a); else pass_cnt++;
        accept();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [DW-1:0] exp_r;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                set_vec(32'h0, 32'h0001_0000);
                bias  = 32'h0001_8000;
                exp_r = 32'h0001_8000;
            end else begin
                set_vec(32'h0001_0000, 32'h0001_0000);
                bias  = 32'h0;
                exp_r = 32'h000A_0000;
            end
            run_eval(lat, bc);
            total_cnt++; if (lat !== 11) $display("FAIL b2b_latency k=%0d got=%0d exp=11", k, lat); else pass_cnt++;
            total_cnt++; if (result_a !== exp_r) $display("FAIL b2b_result k=%0d got=%h exp=%h", k, result_a, exp_r); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (out_valid_a !== 1'b0) $display("FAIL b2b_handshake k=%0d got=%b exp=0", k, out_valid_a); else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_bias_signed();
        test_saturation();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
